// File: rtl/nn_pkg.sv
// nn_pkg: widths shared by the mem_sys read/write sequencers and the
// state encoding of the wx_fetch read sequencer.
package nn_pkg;

  localparam int NN_W_ADDR_LEN = 20;
  localparam int NN_X_ADDR_LEN = 10;
  localparam int NN_W_SEL_LEN  = 2;
  localparam int NN_X_SEL_LEN  = 2;
  localparam int NN_DATA_LEN   = 1;

  // A read command walks IDLE -> FETCH -> DRAIN -> DONE -> IDLE.
  // A zero-length command jumps straight from IDLE to DONE.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } wx_fetch_state_t;

endpackage

// File: rtl/wx_fifo2.sv
// wx_fifo2: two-entry synchronous FIFO. A push and a pop in the same
// cycle are both honoured, including when the FIFO is full, because the
// slot being popped is the one the push lands in.
module wx_fifo2 #(
  parameter int WIDTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic [1:0]       count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem_q [2];
  logic             rd_ptr_q;
  logic             wr_ptr_q;
  logic [1:0]       count_q;
  logic [1:0]       count_d;
  logic             do_push;
  logic             do_pop;

  // Qualify push/pop against occupancy and work out the next count.
  always_comb begin
    do_pop  = pop && (count_q != 2'd0);
    do_push = push && ((count_q != 2'd2) || do_pop);
    count_d = count_q;
    if (do_push && !do_pop) begin
      count_d = count_q + 2'd1;
    end else if (do_pop && !do_push) begin
      count_d = count_q - 2'd1;
    end
  end

  // Storage, pointers and count.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= din;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (do_pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      count_q <= count_d;
    end
  end

  assign dout  = mem_q[rd_ptr_q];
  assign count = count_q;
  assign full  = (count_q == 2'd2);
  assign empty = (count_q == 2'd0);

endmodule

// File: rtl/wx_fetch.sv
// wx_fetch: read-side sequencer for mem_sys. Walks weight and input
// addresses from the command bases, hides the one-cycle memory read
// latency behind a two-entry FIFO and streams {weight, input} bit pairs
// out on a valid/ready interface. Write enables stay low.
// Optional feature macro: WX_FETCH_XNOR_EN adds out_xnor and a running
// xnor_sum count of handshaken beats whose bits agree.
module wx_fetch
  import nn_pkg::*;
#(
  parameter int W_ADDR_LEN = NN_W_ADDR_LEN,
  parameter int X_ADDR_LEN = NN_X_ADDR_LEN,
  parameter int W_SEL_LEN  = NN_W_SEL_LEN,
  parameter int X_SEL_LEN  = NN_X_SEL_LEN
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [W_SEL_LEN-1:0]  cmd_w_sel,
  input  logic [X_SEL_LEN-1:0]  cmd_x_sel,
  input  logic [W_ADDR_LEN-1:0] cmd_w_base,
  input  logic [X_ADDR_LEN-1:0] cmd_x_base,
  input  logic [X_ADDR_LEN-1:0] cmd_len,
  output logic [W_ADDR_LEN-1:0] address_w,
  output logic [X_ADDR_LEN-1:0] address_x,
  output logic [W_SEL_LEN-1:0]  sel_w,
  output logic [X_SEL_LEN-1:0]  sel_x,
  output logic                  we_w,
  output logic                  we_x,
  input  logic                  data_out_w,
  input  logic                  data_out_x,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_w,
  output logic                  out_x,
  output logic                  out_last,
  output logic                  busy,
  output logic                  done
`ifdef WX_FETCH_XNOR_EN
  ,
  output logic                  out_xnor,
  output logic [X_ADDR_LEN:0]   xnor_sum
`endif
);

  localparam int PAIR_LEN = 2 * NN_DATA_LEN;

  wx_fetch_state_t state_q, state_d;

  logic [W_SEL_LEN-1:0]  w_sel_q;
  logic [X_SEL_LEN-1:0]  x_sel_q;
  logic [W_ADDR_LEN-1:0] w_base_q;
  logic [X_ADDR_LEN-1:0] x_base_q;
  logic [X_ADDR_LEN-1:0] len_q;
  logic [X_ADDR_LEN-1:0] len_last;
  logic [X_ADDR_LEN-1:0] issue_cnt_q, issue_cnt_d;
  logic [X_ADDR_LEN-1:0] pop_cnt_q, pop_cnt_d;
  logic                  inflight_q;

  logic [W_ADDR_LEN-1:0] addr_w_hold_q;
  logic [X_ADDR_LEN-1:0] addr_x_hold_q;
  logic [W_SEL_LEN-1:0]  sel_w_hold_q;
  logic [X_SEL_LEN-1:0]  sel_x_hold_q;

  logic                  start_ok;
  logic                  accept;
  logic                  issue;
  logic                  pop;
  logic [2:0]            occupancy;

  logic [PAIR_LEN-1:0]   fifo_dout;
  logic [1:0]            fifo_count;
  logic                  fifo_full;
  logic                  fifo_empty;

  // Captured memory data lands in the FIFO the cycle after its read issues.
  wx_fifo2 #(
    .WIDTH(PAIR_LEN)
  ) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (inflight_q),
    .pop  (pop),
    .din  ({data_out_w, data_out_x}),
    .dout (fifo_dout),
    .count(fifo_count),
    .full (fifo_full),
    .empty(fifo_empty)
  );

  assign out_valid = ~fifo_empty;
  assign out_w     = out_valid & fifo_dout[1];
  assign out_x     = out_valid & fifo_dout[0];
  assign len_last  = len_q - X_ADDR_LEN'(1);
  assign out_last  = out_valid && (state_q == FETCH || state_q == DRAIN) &&
                     (pop_cnt_q == len_last);
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);
  assign we_w      = 1'b0;
  assign we_x      = 1'b0;

  // Read issue: keep buffered plus in-flight data (after this cycle's pop)
  // below two so the FIFO can always absorb what the memory returns.
  always_comb begin
    start_ok  = (state_q == IDLE) && start;
    accept    = start_ok && (cmd_len != '0);
    pop       = out_valid & out_ready;
    occupancy = {1'b0, fifo_count} + {2'b00, inflight_q};
    issue     = (state_q == FETCH) && (issue_cnt_q != len_q) &&
                !(fifo_full && !pop) &&
                (occupancy < (3'd2 + {2'b00, pop}));
  end

  // Memory port: a new address/select only on an issuing cycle, otherwise
  // the last presented values are held.
  always_comb begin
    address_w = addr_w_hold_q;
    address_x = addr_x_hold_q;
    sel_w     = sel_w_hold_q;
    sel_x     = sel_x_hold_q;
    if (issue) begin
      address_w = w_base_q + W_ADDR_LEN'(issue_cnt_q);
      address_x = x_base_q + issue_cnt_q;
      sel_w     = w_sel_q;
      sel_x     = x_sel_q;
    end
  end

  // Next-state logic and issue/pop counter updates.
  always_comb begin
    state_d     = state_q;
    issue_cnt_d = issue_cnt_q;
    pop_cnt_d   = pop_cnt_q;
    if (accept) begin
      issue_cnt_d = '0;
      pop_cnt_d   = '0;
    end else begin
      if (issue) begin
        issue_cnt_d = issue_cnt_q + X_ADDR_LEN'(1);
      end
      if (pop) begin
        pop_cnt_d = pop_cnt_q + X_ADDR_LEN'(1);
      end
    end
    case (state_q)
      IDLE: begin
        if (start_ok) begin
          state_d = (cmd_len == '0) ? DONE : FETCH;
        end
      end
      FETCH: begin
        if (issue && (issue_cnt_q == len_last)) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (pop && out_last) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, command latches, counters and held memory-port values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      w_sel_q       <= '0;
      x_sel_q       <= '0;
      w_base_q      <= '0;
      x_base_q      <= '0;
      len_q         <= '0;
      issue_cnt_q   <= '0;
      pop_cnt_q     <= '0;
      inflight_q    <= 1'b0;
      addr_w_hold_q <= '0;
      addr_x_hold_q <= '0;
      sel_w_hold_q  <= '0;
      sel_x_hold_q  <= '0;
    end else begin
      state_q     <= state_d;
      issue_cnt_q <= issue_cnt_d;
      pop_cnt_q   <= pop_cnt_d;
      inflight_q  <= issue;
      if (accept) begin
        w_sel_q  <= cmd_w_sel;
        x_sel_q  <= cmd_x_sel;
        w_base_q <= cmd_w_base;
        x_base_q <= cmd_x_base;
        len_q    <= cmd_len;
      end
      if (issue) begin
        addr_w_hold_q <= address_w;
        addr_x_hold_q <= address_x;
        sel_w_hold_q  <= sel_w;
        sel_x_hold_q  <= sel_x;
      end
    end
  end

`ifdef WX_FETCH_XNOR_EN
  logic [X_ADDR_LEN:0] xnor_sum_q, xnor_sum_d;

  assign out_xnor = out_valid & ~(out_w ^ out_x);
  assign xnor_sum = xnor_sum_q;

  // Count agreeing pairs as they are handed off; cleared by a new command.
  always_comb begin
    xnor_sum_d = xnor_sum_q;
    if (start_ok) begin
      xnor_sum_d = '0;
    end else if (pop && out_xnor) begin
      xnor_sum_d = xnor_sum_q + (X_ADDR_LEN + 1)'(1);
    end
  end

  // Running agreement count register.
  always_ff @(posedge clk) begin
    if (rst) begin
      xnor_sum_q <= '0;
    end else begin
      xnor_sum_q <= xnor_sum_d;
    end
  end
`endif

endmodule

// File: tb/tb_wx_fetch.sv
// tb_wx_fetch: scoreboard bench for wx_fetch. A behavioural mem_sys model
// returns table bits one cycle after the address; expected beats are
// computed from base+index address arithmetic and queued when a command
// is issued, and a monitor pops and compares on every handshake.
module tb_wx_fetch;

  localparam int WA = 20;
  localparam int XA = 10;
  localparam int WS = 2;
  localparam int XS = 2;

  typedef struct {
    bit w;
    bit x;
    bit last;
  } beat_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [WS-1:0] cmd_w_sel;
  logic [XS-1:0] cmd_x_sel;
  logic [WA-1:0] cmd_w_base;
  logic [XA-1:0] cmd_x_base;
  logic [XA-1:0] cmd_len;
  logic [WA-1:0] address_w;
  logic [XA-1:0] address_x;
  logic [WS-1:0] sel_w;
  logic [XS-1:0] sel_x;
  logic          we_w;
  logic          we_x;
  logic          data_out_w = 1'b0;
  logic          data_out_x = 1'b0;
  logic          out_valid;
  logic          out_ready;
  logic          out_w;
  logic          out_x;
  logic          out_last;
  logic          busy;
  logic          done;
`ifdef WX_FETCH_XNOR_EN
  logic          out_xnor;
  logic [XA:0]   xnor_sum;
`endif

  int    checks = 0;
  int    fails = 0;
  int    cyc = 0;
  int    doneCnt = 0;
  int    doneCyc = 0;
  int    beatCnt = 0;
  beat_t expQ[$];
  beat_t mon;
  bit    wtab[256];
  bit    xtab[256];

  bit         trackAddr = 1'b0;
  int         axSeq[$];
  int         trackPops = 0;
  int         maxOut = 0;
  logic [9:0] prevAx = '0;

  wx_fetch dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .cmd_w_sel (cmd_w_sel),
    .cmd_x_sel (cmd_x_sel),
    .cmd_w_base(cmd_w_base),
    .cmd_x_base(cmd_x_base),
    .cmd_len   (cmd_len),
    .address_w (address_w),
    .address_x (address_x),
    .sel_w     (sel_w),
    .sel_x     (sel_x),
    .we_w      (we_w),
    .we_x      (we_x),
    .data_out_w(data_out_w),
    .data_out_x(data_out_x),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_w     (out_w),
    .out_x     (out_x),
    .out_last  (out_last),
    .busy      (busy),
    .done      (done)
`ifdef WX_FETCH_XNOR_EN
    ,
    .out_xnor  (out_xnor),
    .xnor_sum  (xnor_sum)
`endif
  );

  always #5 clk = ~clk;

  // Cycle index: the cycle that begins at a rising edge carries that count.
  always @(posedge clk) cyc <= cyc + 1;

  // Bank-aware memory lookup: the select rotates which table entry an
  // address maps to, so a wrong select or wrong address shows up as data.
  function automatic int idxW(input int sel, input int addr);
    return ((addr % 256) + sel * 37) % 256;
  endfunction

  function automatic int idxX(input int sel, input int addr);
    return ((addr % 256) + sel * 53) % 256;
  endfunction

  // mem_sys stand-in: synchronous read, data valid the cycle after the address.
  always @(posedge clk) begin
    data_out_w <= wtab[idxW(int'(sel_w), int'(address_w))];
    data_out_x <= xtab[idxX(int'(sel_x), int'(address_x))];
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic logic readyFor(input int mode, input int p);
    case (mode)
      0: return 1'b1;
      1: begin
        case (p % 6)
          0, 3, 5: return 1'b1;
          default: return 1'b0;
        endcase
      end
      default: return ($urandom_range(0, 3) != 0);
    endcase
  endfunction

  // Monitor: write-enable watch, done timestamps, address trace and the
  // scoreboard comparison on every handshake.
  always @(negedge clk) begin
    if (!rst) begin
      checkOutput("we_low", {62'd0, we_w, we_x}, 64'd0);
      if (done) begin
        doneCnt++;
        doneCyc = cyc;
      end
      if (trackAddr && busy && (address_x != prevAx)) begin
        axSeq.push_back(int'(address_x));
        prevAx = address_x;
      end
      if (out_valid && out_ready) begin
        beatCnt++;
        if (trackAddr) trackPops++;
        if (expQ.size() == 0) begin
          checkOutput("unexpected_beat", 1, 0);
        end else begin
          mon = expQ.pop_front();
          checkOutput("out_w", out_w, mon.w);
          checkOutput("out_x", out_x, mon.x);
          checkOutput("out_last", out_last, mon.last);
`ifdef WX_FETCH_XNOR_EN
          checkOutput("out_xnor", out_xnor, (mon.w == mon.x));
`endif
        end
      end
      if (trackAddr && (axSeq.size() - trackPops) > maxOut) begin
        maxOut = axSeq.size() - trackPops;
      end
    end
  end

  // Reference model: beat i reads address base+i modulo the port width.
  task automatic buildExpected(input int wsel, input int xsel, input int wbase,
                               input int xbase, input int len, output int xs);
    beat_t b;
    int aw;
    int ax;
    xs = 0;
    for (int i = 0; i < len; i++) begin
      aw = (wbase + i) % (1 << WA);
      ax = (xbase + i) % (1 << XA);
      b.w = wtab[idxW(wsel, aw)];
      b.x = xtab[idxX(xsel, ax)];
      b.last = (i == len - 1);
      expQ.push_back(b);
      if (b.w == b.x) xs++;
    end
  endtask

  // Issue one command, drive out_ready per mode, optionally fire a stray
  // start mid-command, and wait (bounded) for done.
  task automatic applyStimulus(input int wsel, input int xsel, input int wbase,
                               input int xbase, input int len, input int mode,
                               input int inject);
    int t0;
    int d0;
    int n;
    int pi;
    int xs;
    buildExpected(wsel, xsel, wbase, xbase, len, xs);
    cmd_w_sel  = WS'(wsel);
    cmd_x_sel  = XS'(xsel);
    cmd_w_base = WA'(wbase);
    cmd_x_base = XA'(xbase);
    cmd_len    = XA'(len);
    start      = 1'b1;
    t0 = cyc;
    d0 = doneCnt;
    pi = 0;
    out_ready = readyFor(mode, pi);
    pi++;
    @(posedge clk); #1;
    start = 1'b0;
    n = 0;
    while (doneCnt == d0 && n < 400) begin
      if (n == inject) begin
        start      = 1'b1;
        cmd_len    = XA'(3);
        cmd_w_base = WA'($urandom_range(0, 1000));
        cmd_x_base = XA'($urandom_range(0, 1000));
      end else begin
        start = 1'b0;
      end
      out_ready = readyFor(mode, pi);
      pi++;
      @(posedge clk); #1;
      n++;
    end
    start = 1'b0;
    if (doneCnt == d0) begin
      checkOutput("done_timeout", 0, 1);
    end else if (mode == 0) begin
      checkOutput("done_cycle", doneCyc, (len == 0) ? t0 + 1 : t0 + len + 3);
    end
    checkOutput("beats_missing", expQ.size(), 0);
    checkOutput("busy_after_done", busy, 0);
    expQ.delete();
`ifdef WX_FETCH_XNOR_EN
    checkOutput("xnor_sum", xnor_sum, xs);
`endif
  endtask

  task automatic checkResetValues();
    checkOutput("rst_address_w", address_w, 0);
    checkOutput("rst_address_x", address_x, 0);
    checkOutput("rst_sel_w", sel_w, 0);
    checkOutput("rst_sel_x", sel_x, 0);
    checkOutput("rst_out_valid", out_valid, 0);
    checkOutput("rst_out_w", out_w, 0);
    checkOutput("rst_out_x", out_x, 0);
    checkOutput("rst_out_last", out_last, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_we", {62'd0, we_w, we_x}, 0);
`ifdef WX_FETCH_XNOR_EN
    checkOutput("rst_out_xnor", out_xnor, 0);
    checkOutput("rst_xnor_sum", xnor_sum, 0);
`endif
  endtask

  task automatic startTracking();
    axSeq.delete();
    trackPops = 0;
    maxOut = 0;
    prevAx = address_x;
    trackAddr = 1'b1;
  endtask

  // Hard stop if something wedges the run.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Main sequence.
  initial begin
    int basicW[10];
    int basicX[10];
    int wrapAx[4];
    int xs;
    int n;
    int b0;
    int bz;
    logic [WA-1:0] holdW;
    logic [XA-1:0] holdX;

    basicW = '{1, 0, 1, 1, 0, 1, 0, 0, 1, 1};
    basicX = '{0, 1, 1, 0, 1, 0, 0, 1, 1, 0};
    wrapAx = '{1022, 1023, 0, 1};
    for (int k = 0; k < 256; k++) begin
      wtab[k] = 1'($urandom_range(0, 1));
      xtab[k] = 1'($urandom_range(0, 1));
    end

    rst = 1'b1;
    start = 1'b0;
    cmd_w_sel = '0;
    cmd_x_sel = '0;
    cmd_w_base = '0;
    cmd_x_base = '0;
    cmd_len = '0;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkResetValues();
    rst = 1'b0;
    @(posedge clk); #1;

    $display("[TB] basic read");
    for (int k = 0; k < 10; k++) begin
      wtab[k] = 1'(basicW[k]);
      xtab[k] = 1'(basicX[k]);
    end
    applyStimulus(0, 0, 0, 0, 10, 0, -1);
`ifdef WX_FETCH_XNOR_EN
    checkOutput("xnor_sum_basic", xnor_sum, 3);
`endif

    $display("[TB] backpressure");
    startTracking();
    applyStimulus(1, 2, 100, 200, 6, 1, -1);
    trackAddr = 1'b0;
    checkOutput("bp_issue_count", axSeq.size(), 6);
    checkOutput("bp_max_outstanding_le2", (maxOut <= 2), 1);

    $display("[TB] zero length");
    holdW = address_w;
    holdX = address_x;
    bz = beatCnt;
    applyStimulus(3, 3, 777, 555, 0, 0, -1);
    checkOutput("zero_address_w", address_w, holdW);
    checkOutput("zero_address_x", address_x, holdX);
    checkOutput("zero_no_beats", beatCnt - bz, 0);

    $display("[TB] wrap-around");
    startTracking();
    applyStimulus(2, 1, (1 << WA) - 2, 1022, 4, 0, -1);
    trackAddr = 1'b0;
    checkOutput("wrap_issue_count", axSeq.size(), 4);
    for (int i = 0; i < 4; i++) begin
      if (i < axSeq.size()) checkOutput("wrap_address_x", axSeq[i], wrapAx[i]);
    end

    $display("[TB] reset mid-command");
    b0 = beatCnt;
    buildExpected(1, 2, 50, 60, 8, xs);
    cmd_w_sel = 2'd1;
    cmd_x_sel = 2'd2;
    cmd_w_base = WA'(50);
    cmd_x_base = XA'(60);
    cmd_len = XA'(8);
    out_ready = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n = 0;
    while (!((beatCnt - b0) == 2 && out_valid) && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    checkOutput("reset_third_beat_seen", (n < 50), 1);
    rst = 1'b1;
    @(posedge clk); #1;
    checkResetValues();
    rst = 1'b0;
    expQ.delete();
    @(posedge clk); #1;
    applyStimulus(3, 0, 300, 400, 7, 0, -1);

    $display("[TB] start while busy");
    applyStimulus(0, 0, 0, 0, 10, 0, 4);
    applyStimulus(1, 3, 12345, 900, 9, 1, 2);

    $display("[TB] randomized commands");
    for (int r = 0; r < 10; r++) begin
      for (int k = 0; k < 256; k++) begin
        wtab[k] = 1'($urandom_range(0, 1));
        xtab[k] = 1'($urandom_range(0, 1));
      end
      applyStimulus(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                    int'($urandom_range(0, (1 << WA) - 1)), int'($urandom_range(0, 1023)),
                    int'($urandom_range(1, 24)), 2, -1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/wx_fetch.md
# wx_fetch

Read-side sequencer for `mem_sys`, the counterpart of the load path that writes weights and inputs into it. Given a bank select, base addresses and a length, it drives `mem_sys` read addresses and hides the memory's one-cycle read latency. It returns paired weight/input bits as a valid/ready stream to the compute datapath. While it owns the memory port, it holds both write enables low.

## Interface
Parameters:
- W_ADDR_LEN, 20, weight address width
- X_ADDR_LEN, 10, input address width; also the width of the `len` count
- W_SEL_LEN, 2, weight bank select width
- X_SEL_LEN, 2, input bank select width

Ports:
- clk  in  1  clock; one clock domain only
- rst  in  1  synchronous, active-high reset
- start  in  1  command strobe; ignored while busy=1
- cmd_w_sel  in  W_SEL_LEN  weight bank for the command
- cmd_x_sel  in  X_SEL_LEN  input bank for the command
- cmd_w_base  in  W_ADDR_LEN  first weight address
- cmd_x_base  in  X_ADDR_LEN  first input address
- cmd_len  in  X_ADDR_LEN  number of element pairs; 0 is legal
- address_w  out  W_ADDR_LEN  to mem_sys
- address_x  out  X_ADDR_LEN  to mem_sys
- sel_w  out  W_SEL_LEN  to mem_sys
- sel_x  out  X_SEL_LEN  to mem_sys
- we_w  out  1  constant 0
- we_x  out  1  constant 0
- data_out_w  in  1  from mem_sys; valid one cycle after its address
- data_out_x  in  1  from mem_sys; valid one cycle after its address
- out_valid  out  1  stream valid
- out_ready  in  1  stream ready
- out_w  out  1  weight bit
- out_x  out  1  input bit
- out_last  out  1  marks the final pair of the command
- busy  out  1  a command is in progress
- done  out  1  one-cycle pulse when the command completes

## Operation
- FSM states: IDLE, FETCH, DRAIN, DONE.
- IDLE → FETCH:
  - Condition: start=1 and cmd_len≠0.
  - Latch the selects, the bases and cmd_len; clear the issue and pop counters.
- IDLE → DONE: start=1 and cmd_len=0. No reads are issued and no beats are output.
- Issue rule in FETCH:
  - Issue one read per cycle while `fifo_count + inflight − pop < 2`, where `pop = out_valid & out_ready`.
  - Read i drives address_w = w_base+i and address_x = x_base+i.
  - Each address wraps modulo 2^width.
- Inflight flag: set on the cycle a read issues. On the next cycle, {data_out_w, data_out_x} is written into a 2-entry FIFO.
- FETCH → DRAIN: after the last read issues.
- DRAIN → DONE: on the handshake of the beat carrying out_last.
- DONE → IDLE: unconditional. done=1 only in DONE.
- busy=1 in FETCH, DRAIN and DONE.
- Stream data: out_w and out_x come from the FIFO head. Once out_valid rises, the head must not change until it is popped.
- out_last=1 only on the beat whose index is len−1.
- Address and select hold: between issues, and in IDLE, the address and select outputs keep their last values.

## Timing
- Reset values: address_w=0, address_x=0, sel_w=0, sel_x=0, we_w=0, we_x=0, out_valid=0, out_w=0, out_x=0, out_last=0, busy=0, done=0. The FIFO is empty, inflight=0, state is IDLE.
- Latency, with start accepted in cycle T:
  - The first address is presented in T+1.
  - Memory data arrives in T+2.
  - out_valid=1 in T+3.
- Throughput: with out_ready held at 1, one beat per cycle. len N gives done in cycle T+N+3.
- Backpressure:
  - With out_ready=0, at most 2 reads can be buffered or in flight. Issue stalls.
  - Nothing is dropped and nothing is duplicated.
- start during busy: ignored, with no effect on the current command.
- start in the same cycle as done: ignored. start is accepted only in IDLE.
- rst mid-command: on the next edge, all state and outputs return to their reset values. Partial beats are discarded.

## Configuration
- WX_FETCH_XNOR_EN defined:
  - Adds an output `out_xnor` (1 bit) = ~(out_w ^ out_x), valid with out_valid. Reset value 0.
  - Adds an output `xnor_sum` (X_ADDR_LEN+1 bits). It is the running count of handshaken beats with out_xnor=1. It clears on command accept and holds its value after done.
- WX_FETCH_XNOR_EN undefined: neither port exists and there is no accumulator logic.

## Structure
- Shared package `nn_pkg`:
  - Address, data and select width constants.
  - The FSM state enum `wx_fetch_state_t`.
- One sub-module: `wx_fifo2`, a 2-entry synchronous FIFO.
  - Interface: push, pop, din, dout, count, full, empty.
  - Reset: synchronous, active-high.
  - Full and empty behave as a proper FIFO. A simultaneous push and pop with count=1 keeps count at 1.

## Test plan
- Basic read:
  - Stimulus: memory loaded with W1 = 1,0,1,1,0,1,0,0,1,1 and X = 0,1,1,0,1,0,0,1,1,0; start with w_base=0, x_base=0, len=10, out_ready=1.
  - Required response: 10 beats match the loaded data in order; out_last on beat 10; done at T+13; we_w and we_x are 0 throughout.
- Backpressure:
  - Stimulus: len=6; out_ready toggles 1,0,0,1,0,1…
  - Required response: the same 6 pairs, in order, with no duplicates. No more than 2 reads are outstanding at any time.
- Zero length: len=0 → done in T+1, no out_valid, and address_w/address_x unchanged.
- Wrap-around: x_base=1022, len=4 → address_x sequence 1022, 1023, 0, 1.
- Reset mid-command: rst asserted on the 3rd beat → the next cycle shows all reset values. A new command then runs correctly.
- Busy start and XNOR count:
  - A start pulse mid-command is ignored, and beat count and order are unchanged.
  - With WX_FETCH_XNOR_EN defined and the basic-read data, xnor_sum=3 after done.
